// File: rtl/shared_port_ram_arbiter_pkg.sv
// shared_port_ram_arbiter_pkg: shared widths and read latency.
// SHARED_RAM_OUTPUT_REG_EN selects the two-stage output pipeline.
package shared_port_ram_arbiter_pkg;
  function automatic int port_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
`ifdef SHARED_RAM_OUTPUT_REG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif
endpackage

// File: rtl/shared_port_ram_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, scanning from last_grant+1.
module rr_arbiter
  import shared_port_ram_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int IW = port_idx_width(N);
  logic [IW-1:0] last_q, last_d;
  // Scan farthest-first so the nearest requester after last_q overwrites the rest.
  always_comb begin
    grant = '0;
    last_d = last_q;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last_q) + i) % N]) last_d = IW'((int'(last_q) + i) % N);
    if (|req) grant[last_d] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= IW'(N - 1);
    else last_q <= last_d;
endmodule

// File: rtl/shared_port_ram_arbiter.sv
// shared_port_ram_arbiter: byte-writable single-port RAM shared round-robin.
// SHARED_RAM_OUTPUT_REG_EN adds a second dout/dout_valid stage (latency 2).
module shared_port_ram_arbiter
  import shared_port_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   write_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     din,
  output logic [NUM_PORTS-1:0]                ack,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic [NUM_PORTS-1:0]                dout_valid
);
  localparam int BW = be_width(DATA_WIDTH);
  logic [NUM_PORTS-1:0] grant, vld_q, vld_d;
  logic [BW-1:0] we_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] din_s, dout_q, dout_d;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic rd;
  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant)
  );
  assign ack = grant;
  always_comb begin
    we_s = '0;
    addr_s = '0;
    din_s = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) begin
        we_s = write_en[i*BW +: BW];
        addr_s = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        din_s = din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    rd = |grant && ~|we_s;
    dout_d = rd ? mem[addr_s] : dout_q;
    vld_d = rd ? grant : '0;
  end
  // Array is left unreset so it maps onto a RAM primitive.
  always_ff @(posedge clk)
    if (|grant)
      for (int b = 0; b < BW; b++)
        if (we_s[b]) mem[addr_s][b*8 +: 8] <= din_s[b*8 +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dout_q <= '0;
      vld_q <= '0;
    end else begin
      dout_q <= dout_d;
      vld_q <= vld_d;
    end
`ifdef SHARED_RAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q;
  logic [NUM_PORTS-1:0] vld2_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dout2_q <= '0;
      vld2_q <= '0;
    end else begin
      dout2_q <= dout_q;
      vld2_q <= vld_q;
    end
  assign dout = dout2_q;
  assign dout_valid = vld2_q;
`else
  assign dout = dout_q;
  assign dout_valid = vld_q;
`endif
endmodule

// File: tb/tb_shared_port_ram_arbiter.sv
// tb_shared_port_ram_arbiter: directed + random checks against a behavioural model.
module tb_shared_port_ram_arbiter;
  import shared_port_ram_arbiter_pkg::*;
  localparam int AW = 14, DW = 16, N = 2, BW = DW / 8;
  logic clk = 1'b0, reset;
  logic [N-1:0] req, ack, dout_valid;
  logic [N*BW-1:0] write_en;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] din;
  logic [DW-1:0] dout;
  int errors = 0, checks = 0, w;
  logic [DW-1:0] mem_m [int];
  int lg;
  logic [DW-1:0] sd [2];
  logic [N-1:0] sv [2];
  logic pend [N];

  shared_port_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(N)) dut (
    .clk(clk), .reset(reset), .req(req), .write_en(write_en), .addr(addr),
    .din(din), .ack(ack), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic set(int p, logic r, logic [BW-1:0] we, logic [AW-1:0] a, logic [DW-1:0] d);
    req[p] = r;
    write_en[p*BW +: BW] = we;
    addr[p*AW +: AW] = a;
    din[p*DW +: DW] = d;
  endtask

  task automatic model_reset();
    lg = N - 1;
    for (int s = 0; s < 2; s++) begin
      sd[s] = '0;
      sv[s] = '0;
    end
  endtask

  // One clock: check outputs against the model, then apply the granted access.
  task automatic cycle(string tag, output int win);
    logic [N-1:0] ea;
    logic [BW-1:0] we;
    logic [DW-1:0] d, old;
    int a;
    #1;
    win = -1;
    for (int k = N; k >= 1; k--)
      if (req[(lg + k) % N]) win = (lg + k) % N;
    ea = '0;
    if (win >= 0) ea[win] = 1'b1;
    chk({tag, ".ack"}, 32'(ack), 32'(ea));
    chk({tag, ".dout"}, 32'(dout), 32'(READ_LATENCY == 1 ? sd[0] : sd[1]));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(READ_LATENCY == 1 ? sv[0] : sv[1]));
    @(posedge clk);
    sd[1] = sd[0];
    sv[1] = sv[0];
    sv[0] = '0;
    if (win >= 0) begin
      lg = win;
      we = write_en[win*BW +: BW];
      a = int'(addr[win*AW +: AW]);
      d = din[win*DW +: DW];
      old = mem_m.exists(a) ? mem_m[a] : 'x;
      if (we == '0) begin
        sd[0] = old;
        sv[0][win] = 1'b1;
      end else begin
        for (int b = 0; b < BW; b++)
          if (we[b]) old[b*8 +: 8] = d[b*8 +: 8];
        mem_m[a] = old;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(string tag, int n);
    int x;
    req = '0;
    repeat (n) cycle(tag, x);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    write_en = '0;
    addr = '0;
    din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.ack", 32'(ack), 0);
    chk("rst.dout", 32'(dout), 0);
    chk("rst.valid", 32'(dout_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      set(0, 1'b1, '1, AW'(i), DW'($urandom));
      cycle("fill", w);
    end
    // write then read back
    set(0, 1'b1, 2'b11, 14'h0010, 16'hBEEF);
    cycle("t1w", w);
    set(0, 1'b1, 2'b00, 14'h0010, 16'h0);
    cycle("t1r", w);
    idle("t1lat", READ_LATENCY - 1);
    chk("t1.dout", 32'(dout), 32'h0000BEEF);
    chk("t1.valid", 32'(dout_valid), 32'h1);
    idle("t1idle", 2);
    // byte enables
    set(0, 1'b1, 2'b11, 14'h0020, 16'h1234);
    cycle("bew0", w);
    req = '0;
    set(1, 1'b1, 2'b10, 14'h0020, 16'hAB00);
    cycle("bew1", w);
    req = '0;
    set(0, 1'b1, 2'b00, 14'h0020, 16'h0);
    cycle("ber", w);
    idle("belat", READ_LATENCY - 1);
    chk("be.dout", 32'(dout), 32'h0000AB34);
    idle("beidle", 2);
    // both ports requesting continuously
    set(0, 1'b1, 2'b00, 14'h0001, 16'h0);
    set(1, 1'b1, 2'b00, 14'h0002, 16'h0);
    repeat (6) cycle("rr", w);
    idle("rridle", 3);
    // four back-to-back reads
    for (int k = 0; k < 4; k++) begin
      set(0, 1'b1, 2'b00, AW'(16 + k), 16'h0);
      cycle("b2b", w);
    end
    idle("b2bidle", 3);
    // reset one cycle after a read ack; port0 last held the grant
    set(0, 1'b1, 2'b00, 14'h0010, 16'h0);
    cycle("mr", w);
    req = '0;
    reset = 1'b1;
    #1;
    chk("mr.dout", 32'(dout), 0);
    chk("mr.valid", 32'(dout_valid), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // simultaneous write (port0) and read (port1) of the same word
    set(0, 1'b1, 2'b11, 14'h0005, 16'h5555);
    set(1, 1'b1, 2'b00, 14'h0005, 16'h0);
    #1;
    chk("coll.first", 32'(ack), 32'h1);
    cycle("coll0", w);
    req[0] = 1'b0;
    cycle("coll1", w);
    idle("colllat", READ_LATENCY - 1);
    chk("coll.dout", 32'(dout), 32'h00005555);
    chk("coll.valid", 32'(dout_valid), 32'h2);
    idle("collidle", 2);
    // random traffic obeying the req/ack handshake
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++)
        if (!pend[p]) begin
          if ($urandom_range(3) != 0) begin
            pend[p] = 1'b1;
            set(p, 1'b1, ($urandom_range(1) != 0) ? BW'($urandom) : '0,
                AW'($urandom_range(63)), DW'($urandom));
          end else req[p] = 1'b0;
        end
      cycle("rnd", w);
      if (w >= 0) begin
        pend[w] = 1'b0;
        req[w] = 1'b0;
      end
    end
    idle("end", 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
